// File: rtl/sd_uart_byte_feeder.sv
// ============================================================================
// Module   : sd_uart_byte_feeder
// Purpose  : Byte FIFO plus frame pacing in front of the SD-card UART
//            transmitter. Each byte goes out as a one-cycle po_flag pulse, and
//            po_data is held for the whole frame.
// Options  : SD_UART_FEEDER_STATS_EN adds the tx_count and drop_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_uart_byte_feeder #(
  parameter int UART_BPS     = 921600,
  parameter int CLK_FREQ     = 20_000_000,
  parameter int FIFO_DEPTH   = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    po_data,
  output logic                          po_flag,
  output logic                          busy
`ifdef SD_UART_FEEDER_STATS_EN
  ,
  output logic [15:0]                   tx_count,
  output logic [7:0]                    drop_count
`endif
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS + 1;
  localparam int FRAME_CYCLES = 10 * BAUD_CNT_MAX + GUARD_CYCLES;
  localparam int PW           = $clog2(FIFO_DEPTH);
  localparam int LW           = PW + 1;
  localparam int CW           = $clog2(FRAME_CYCLES + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [CW-1:0]   r_cnt;
  logic            r_overflow;
  logic            r_po_flag;
  logic [7:0]      r_po_data;
  logic            w_full;
  logic            w_wr_acc;
  logic            w_rd;

  // Fullness is judged on the pre-edge level, so a read on the same edge
  // does not make room for a write.
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_wr_acc   = wr_en && !w_full;

  assign fifo_full  = w_full;
  assign fifo_empty = (r_level == '0);
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign po_flag    = r_po_flag;
  assign po_data    = r_po_data;
  assign busy       = (r_state == S_WAIT);

  always_ff @(posedge sys_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_rd        = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CW'(FRAME_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_po_flag  <= 1'b0;
      r_po_data  <= 8'h00;
      r_cnt      <= '0;
    end else begin
      r_overflow <= wr_en && w_full;
      r_po_flag  <= w_rd;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_po_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_rd) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef SD_UART_FEEDER_STATS_EN
  logic [15:0] r_tx_count;
  logic [7:0]  r_drop_count;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tx_count   <= 16'h0000;
      r_drop_count <= 8'h00;
    end else begin
      if (w_rd) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
      if (wr_en && w_full && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_uart_byte_feeder.sv
// ============================================================================
// Module   : tb_sd_uart_byte_feeder
// Purpose  : Self-checking bench with a queue-based reference model and
//            directed plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_uart_byte_feeder;

  localparam int DEPTH = 16;
  localparam int FRAME = 224;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  wr_data   = 8'h00;
  logic        wr_en     = 1'b0;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [7:0]  po_data;
  logic        po_flag;
  logic        busy;
`ifdef SD_UART_FEEDER_STATS_EN
  logic [15:0] tx_count;
  logic [7:0]  drop_count;
`endif

  sd_uart_byte_feeder dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .po_data    (po_data),
    .po_flag    (po_flag),
    .busy       (busy)
`ifdef SD_UART_FEEDER_STATS_EN
    ,
    .tx_count   (tx_count),
    .drop_count (drop_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a byte queue plus the rule that emissions are at least
  // FRAME+1 edges apart. busy covers the FRAME edges that start at an emission.
  logic [7:0]  mq [$];
  int          cyc       = 0;
  int          last_emit = -100000;
  logic        m_flag    = 1'b0;
  logic        m_ovf     = 1'b0;
  logic        m_busy    = 1'b0;
  logic [7:0]  m_data    = 8'h00;
  int          m_tx      = 0;
  int          m_drop    = 0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mq.delete();
      last_emit = -100000;
      m_flag = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_data = 8'h00;
      m_tx = 0; m_drop = 0;
    end else begin
      automatic bit full_pre = (mq.size() == DEPTH);
      cyc++;
      m_ovf  = wr_en && full_pre;
      m_flag = 1'b0;
      if (mq.size() > 0 && cyc >= last_emit + FRAME + 1) begin
        m_data    = mq.pop_front();
        m_flag    = 1'b1;
        last_emit = cyc;
      end
      if (wr_en && !full_pre) mq.push_back(wr_data);
      m_busy = (cyc - last_emit) < FRAME;
      if (m_flag) m_tx = (m_tx + 1) % 65536;
      if (m_ovf && m_drop < 255) m_drop++;
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      check("po_flag",    po_flag,    m_flag);
      check("po_data",    po_data,    m_data);
      check("busy",       busy,       m_busy);
      check("overflow",   overflow,   m_ovf);
      check("fifo_level", fifo_level, mq.size());
      check("fifo_full",  fifo_full,  mq.size() == DEPTH);
      check("fifo_empty", fifo_empty, mq.size() == 0);
`ifdef SD_UART_FEEDER_STATS_EN
      check("tx_count",   tx_count,   m_tx);
      check("drop_count", drop_count, m_drop);
`endif
    end
  end

  // Observed-output log used by the literal expectations.
  logic [7:0] got [$];
  int         got_t [$];
  int         n_flags = 0, n_ovf = 0, n_busy = 0, n_full = 0;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (po_flag) begin got.push_back(po_data); got_t.push_back(cyc); n_flags++; end
      if (overflow)  n_ovf++;
      if (busy)      n_busy++;
      if (fifo_full) n_full++;
    end
  end

  task automatic clear_log();
    got.delete(); got_t.delete();
    n_flags = 0; n_ovf = 0; n_busy = 0; n_full = 0;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge sys_clk);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drain();
    int k = 0;
    while ((!fifo_empty || busy) && k < 20000) begin
      @(negedge sys_clk);
      k++;
    end
    check("drain_timeout", k < 20000, 1);
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_wr;
`ifdef SD_UART_FEEDER_STATS_EN
    int tx0, dr0;
`endif
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Idle after reset
    clear_log();
    idle(500);
    check("idle_flags", n_flags, 0);
    check("idle_empty", fifo_empty, 1);
    check("idle_busy",  busy, 0);
    check("idle_data",  po_data, 8'h00);

    // Single byte: latency, frame length, data hold
    clear_log();
    t_wr = cyc + 1;
    wr(8'hA5);
    idle(300);
    check("single_count",   got.size(), 1);
    if (got.size() == 1) begin
      check("single_data",    got[0], 8'hA5);
      check("single_latency", got_t[0] - t_wr, 1);
    end
    check("single_busy_len", n_busy, 224);
    check("single_hold",     po_data, 8'hA5);

    // Burst of 16: exact fill, no overflow, 225-cycle spacing
    clear_log();
    for (int i = 0; i < 16; i++) wr(8'(i));
    drain();
    check("b16_count", got.size(), 16);
    check("b16_ovf",   n_ovf, 0);
    for (int i = 0; i < got.size() && i < 16; i++) begin
      check("b16_data", got[i], i);
      if (i > 0) check("b16_spacing", got_t[i] - got_t[i-1], 225);
    end

    // Burst of 18: one drop, 17 in order
    clear_log();
`ifdef SD_UART_FEEDER_STATS_EN
    tx0 = tx_count; dr0 = drop_count;
`endif
    for (int i = 0; i < 18; i++) wr(8'h40 + 8'(i));
    drain();
    check("b18_ovf",   n_ovf, 1);
    check("b18_full",  n_full > 0, 1);
    check("b18_count", got.size(), 17);
    for (int i = 0; i < got.size() && i < 17; i++) check("b18_data", got[i], 8'h40 + i);
`ifdef SD_UART_FEEDER_STATS_EN
    check("b18_tx_delta",   tx_count - tx0, 17);
    check("b18_drop_delta", drop_count - dr0, 1);
`endif

    // Level held at 1 across pointer wrap: write on every read edge
    clear_log();
    wr(8'h80);
    check("lvl1_first", fifo_level, 1);
    wr(8'h81);
    check("lvl1_rw", fifo_level, 1);
    for (int i = 2; i < 40; i++) begin
      idle(224);
      wr(8'h80 + 8'(i));
      check("lvl1_rw", fifo_level, 1);
    end
    drain();
    check("lvl1_count", got.size(), 40);
    for (int i = 0; i < got.size() && i < 40; i++) check("lvl1_data", got[i], 8'h80 + i);

    // Reset at cnt=100 with 5 bytes queued
    clear_log();
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    idle(96);
    check("rst_pre_level", fifo_level, 5);
    sys_rst_n = 1'b0;
    #1;
    check("rst_flag",  po_flag, 0);
    check("rst_busy",  busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full",  fifo_full, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_data",  po_data, 8'h00);
    idle(2);
    sys_rst_n = 1'b1;
    clear_log();
    idle(500);
    check("post_rst_flags", n_flags, 0);
    check("post_rst_level", fifo_level, 0);

    // Random traffic in phases of varying write density
    for (int ph = 0; ph < 6; ph++) begin
      automatic int p = $urandom_range(1, 60);
      repeat (1000) begin
        wr_en   = ($urandom_range(0, 99) < p);
        wr_data = 8'($urandom);
        @(negedge sys_clk);
      end
    end
    wr_en = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sd_uart_byte_feeder.md
Name: sd_uart_byte_feeder

Overview:
- Byte buffer and pacing stage directly upstream of the SD-card UART transmitter.
- Accepts bytes from the SD read datapath into a small FIFO and emits one byte at a time as a one-cycle po_flag pulse with po_data.
- The transmitter has no busy output, so this block times each 10-bit frame itself.
- po_data is held stable for the whole frame, because the transmitter samples its data input bit by bit during the frame.

Parameters:
- UART_BPS, 921600, line baud rate; must match the transmitter.
- CLK_FREQ, 20_000_000, sys_clk frequency in Hz.
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 4.
- GUARD_CYCLES, 4, extra idle clocks appended after each frame.
- Derived BAUD_CNT_MAX = CLK_FREQ/UART_BPS+1, giving 22 at the defaults.
- Derived FRAME_CYCLES = 10*BAUD_CNT_MAX+GUARD_CYCLES, giving 224 at the defaults.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- wr_data  in  8  byte from SD read path
- wr_en  in  1  write strobe; one byte per cycle
- fifo_full  out  1  high when level==FIFO_DEPTH
- fifo_empty  out  1  high when level==0
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  one-cycle pulse: write dropped
- po_data  out  8  byte to transmitter; stable between po_flag pulses
- po_flag  out  1  one-cycle start pulse to transmitter
- busy  out  1  high while a frame is in flight (state WAIT)

Behaviour:
- Clock and reset: reset is sys_rst_n, asynchronous, active-low; clock is sys_clk; all state updates on rising edge.
- Reset values:
  - pointers and level 0, so fifo_empty=1, fifo_full=0.
  - overflow=0, po_flag=0, po_data=8'h00, busy=0.
  - state IDLE, frame counter 0.
- FIFO:
  - Circular buffer with $clog2(FIFO_DEPTH)-bit read and write pointers that wrap naturally.
  - Level counter has one extra bit.
  - Write accepted when wr_en=1 and fifo_full=0, judged on the pre-edge level.
  - wr_en=1 while full: byte discarded, pointers unchanged, overflow=1 for one cycle. This holds even if a read happens on the same edge.
  - Simultaneous accepted write and read: level unchanged, both pointers advance.
- FSM states IDLE and WAIT:
  - IDLE, fifo_level>0 on the sampling edge:
    - po_data<=mem[rd_ptr], po_flag<=1, rd_ptr++, level-- (unless a write is accepted the same edge), cnt<=0, state<=WAIT.
  - IDLE, FIFO empty: no change; po_data holds its last value.
  - WAIT: po_flag<=0, busy=1, cnt++. When cnt==FRAME_CYCLES-1, state<=IDLE.
- Latency:
  - wr_en into an empty FIFO at edge N: po_flag is high for the cycle following edge N+1.
  - Back-to-back po_flag spacing with a non-empty FIFO: exactly FRAME_CYCLES+1 clocks (225 at defaults).
- po_data changes only on the edge that raises po_flag.
- Reset mid-frame: FIFO contents and the in-flight byte are lost and the FSM returns to IDLE. The transmitter shares sys_rst_n, so the line returns to idle-high.
- Counter width: $clog2(FRAME_CYCLES+1) bits; no wrap occurs inside WAIT.

Optional Feature:
- Macro SD_UART_FEEDER_STATS_EN.
- Defined:
  - Adds output tx_count[15:0], which increments on every po_flag pulse and wraps 16'hFFFF->0.
  - Adds output drop_count[7:0], which increments on every overflow pulse and saturates at 8'hFF.
  - Both reset to 0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset release, no writes for 500 cycles -> po_flag never high, fifo_empty=1, busy=0, po_data=8'h00.
- Single write 8'hA5 at edge N -> po_flag pulse after edge N+1 with po_data=8'hA5. busy high for 224 cycles; po_data stays 8'hA5 through and after the frame.
- Burst of 16 writes 8'h00..8'h0F on consecutive cycles -> exactly 16 po_flag pulses, spaced 225 cycles apart, carrying data 00..0F in order; no overflow.
- Burst of 18 writes while the first frame is in flight -> fifo_full asserted and 1 overflow pulse (the first byte drains on the second edge). The dropped byte never appears; 17 bytes are emitted in order. With SD_UART_FEEDER_STATS_EN: drop_count=1, tx_count=17.
- Level held at 1 with a write accepted on the same edge as the FSM read -> level stays 1, no data loss, and the byte order is preserved across pointer wrap after 40 bytes.
- sys_rst_n pulsed low at cnt=100 of a frame with 5 bytes queued -> outputs return to reset values immediately, no further po_flag, fifo_level=0.
